button_event: RTL and testbench

- Sits directly downstream of the input debouncer. It consumes one clean, debounced button level and turns it into single-cycle event pulses (press, release, long-press, auto-repeat) plus a held flag.
- Feeds the control/menu logic, which then never handles raw levels or timing itself.
- Thresholds are runtime inputs, in the same style as the debouncer's reload value, so software and top-level straps can tune them.

---
 rtl/button_event.sv | 88 ++++++++
 tb/tb_button_event.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/button_event.sv
// button_event: turns a debounced button level into press/release/long-press/repeat pulses
// plus a held flag, with runtime-tunable long-press and auto-repeat thresholds.
module button_event #(
    parameter bit ACTIVE_HIGH = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_i,
    input  logic [31:0] long_ticks_i,
    input  logic [31:0] repeat_ticks_i,
    input  logic        repeat_en_i,
    output logic        press_o,
    output logic        release_o,
    output logic        long_press_o,
    output logic        repeat_o,
    output logic        held_o
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PRESSED = 2'd1;
    localparam logic [1:0] LONG    = 2'd2;

    logic        lvl;
    logic [1:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        prev_q;
    logic        press_d, release_d, long_d, repeat_d, held_d;

    assign lvl = in_i ~^ ACTIVE_HIGH;

    // Release wins over any pending long/repeat expiry in the same cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        if (state_q == IDLE) begin
            if (lvl && !prev_q) begin
                press_d = 1'b1;
                state_d = PRESSED;
                cnt_d   = long_ticks_i;
            end
        end else if (!lvl) begin
            release_d = 1'b1;
            state_d   = IDLE;
            cnt_d     = '0;
        end else if (state_q == PRESSED) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 32'd1;
            end else begin
                long_d  = 1'b1;
                state_d = LONG;
                cnt_d   = repeat_ticks_i;
            end
        end else if (!repeat_en_i) begin
            cnt_d = repeat_ticks_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 32'd1;
        end else begin
            repeat_d = 1'b1;
            cnt_d    = repeat_ticks_i;
        end
        held_d = state_d != IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            prev_q       <= 1'b0;
            press_o      <= 1'b0;
            release_o    <= 1'b0;
            long_press_o <= 1'b0;
            repeat_o     <= 1'b0;
            held_o       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prev_q       <= lvl;
            press_o      <= press_d;
            release_o    <= release_d;
            long_press_o <= long_d;
            repeat_o     <= repeat_d;
            held_o       <= held_d;
        end
    end
endmodule

// File: tb/tb_button_event.sv
// tb_button_event: timestamp-based reference model checked every cycle against an
// active-high and an active-low instance, plus literal timing pins for directed scenarios.
module tb_button_event;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in  = 1'b0;
    logic        en  = 1'b0;
    logic [31:0] lt  = 32'd100;
    logic [31:0] rt  = 32'd0;
    logic        nin;
    logic        p0, r0, l0, q0, h0;
    logic        p1, r1, l1, q1, h1;

    assign nin = ~in;
    always #5 clk = ~clk;

    button_event #(.ACTIVE_HIGH(1'b1)) dut0 (
        .clk(clk), .rst(rst), .in_i(in), .long_ticks_i(lt), .repeat_ticks_i(rt),
        .repeat_en_i(en), .press_o(p0), .release_o(r0), .long_press_o(l0),
        .repeat_o(q0), .held_o(h0)
    );

    button_event #(.ACTIVE_HIGH(1'b0)) dut1 (
        .clk(clk), .rst(rst), .in_i(nin), .long_ticks_i(lt), .repeat_ticks_i(rt),
        .repeat_en_i(en), .press_o(p1), .release_o(r1), .long_press_o(l1),
        .repeat_o(q1), .held_o(h1)
    );

    int     n_chk = 0;
    int     n_fail = 0;
    int     e = 0;
    bit     m_act, m_long, m_prev;
    longint due;
    bit     ep, er, el, eq, eh;
    int     press_q[$], rel_q[$], long_q[$], rep_q[$];

    task automatic chk(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %b expected %b", nm, e, act, exp);
        end
    endtask

    task automatic lit(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1000;
    endfunction

    task automatic clear_logs();
        press_q.delete();
        rel_q.delete();
        long_q.delete();
        rep_q.delete();
    endtask

    // The model tracks the absolute edge at which the next long/repeat is due,
    // rather than a down-counter.
    task automatic tick();
        @(negedge clk);
        if (rst) begin
            m_act = 0; m_long = 0; m_prev = 0;
            {ep, er, el, eq, eh} = 5'b0;
        end else begin
            e++;
            {ep, er, el, eq} = 4'b0;
            if (!m_act) begin
                if (in && !m_prev) begin
                    ep = 1; m_act = 1; m_long = 0;
                    due = longint'(e) + longint'(lt) + 64'd1;
                end
            end else if (!in) begin
                er = 1; m_act = 0;
            end else if (!m_long) begin
                if (e == due) begin
                    el = 1; m_long = 1;
                    due = longint'(e) + longint'(rt) + 64'd1;
                end
            end else if (!en) begin
                due = longint'(e) + longint'(rt) + 64'd1;
            end else if (e == due) begin
                eq = 1;
                due = longint'(e) + longint'(rt) + 64'd1;
            end
            eh = m_act;
            m_prev = in;
            if (ep) press_q.push_back(e);
            if (er) rel_q.push_back(e);
            if (el) long_q.push_back(e);
            if (eq) rep_q.push_back(e);
        end
        chk("press", p0, ep);
        chk("release", r0, er);
        chk("long_press", l0, el);
        chk("repeat", q0, eq);
        chk("held", h0, eh);
        chk("press_low", p1, ep);
        chk("release_low", r1, er);
        chk("long_press_low", l1, el);
        chk("repeat_low", q1, eq);
        chk("held_low", h1, eh);
    endtask

    int k;

    initial begin
        // Short press well below the long threshold
        repeat (3) tick();
        rst = 0;
        repeat (7) tick();
        clear_logs();
        in = 1;
        repeat (3) tick();
        in = 0;
        repeat (3) tick();
        lit("A press count", press_q.size(), 1);
        lit("A release offset", at(rel_q, 0) - at(press_q, 0), 3);
        lit("A long count", long_q.size(), 0);

        // Long press with auto-repeat
        lt = 5; rt = 2; en = 1;
        clear_logs();
        in = 1;
        repeat (20) tick();
        in = 0;
        repeat (3) tick();
        k = at(press_q, 0);
        lit("B long offset", at(long_q, 0) - k, 6);
        lit("B repeat count", rep_q.size(), 4);
        for (int i = 0; i < 4; i++) lit("B repeat offset", at(rep_q, i) - k, 9 + 3 * i);
        lit("B release offset", at(rel_q, 0) - k, 20);

        // repeat_en enabled late starts a fresh period
        en = 0;
        clear_logs();
        in = 1;
        repeat (11) tick();
        en = 1;
        repeat (9) tick();
        in = 0;
        repeat (3) tick();
        k = at(press_q, 0);
        lit("C long offset", at(long_q, 0) - k, 6);
        lit("C first repeat", at(rep_q, 0) - k, 13);
        lit("C second repeat", at(rep_q, 1) - k, 16);

        // Zero thresholds; release overrides a due repeat
        lt = 0; rt = 0; en = 1;
        clear_logs();
        in = 1;
        repeat (4) tick();
        in = 0;
        repeat (2) tick();
        k = at(press_q, 0);
        lit("D long offset", at(long_q, 0) - k, 1);
        lit("D repeat count", rep_q.size(), 2);
        lit("D repeat0", at(rep_q, 0) - k, 2);
        lit("D repeat1", at(rep_q, 1) - k, 3);
        lit("D release offset", at(rel_q, 0) - k, 4);

        // Held through reset, then reset pulsed mid-hold
        lt = 100;
        clear_logs();
        in = 1;
        rst = 1;
        repeat (2) tick();
        rst = 0;
        tick();
        lit("E press first edge", at(press_q, 0), e);
        repeat (2) tick();
        rst = 1;
        #1;
        chk("E async held", h0, 1'b0);
        chk("E async held_low", h1, 1'b0);
        chk("E async press", p0, 1'b0);
        repeat (2) tick();
        rst = 0;
        tick();
        lit("E press count", press_q.size(), 2);
        lit("E release count", rel_q.size(), 0);
        in = 0;
        repeat (2) tick();

        // Randomized traffic, including mid-count threshold changes and reset pulses
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 9) == 0) in = ~in;
            if ($urandom_range(0, 19) == 0) lt = $urandom_range(0, 6);
            if ($urandom_range(0, 19) == 0) rt = $urandom_range(0, 3);
            if ($urandom_range(0, 14) == 0) en = ~en;
            if (rst) rst = 0;
            else if ($urandom_range(0, 499) == 0) rst = 1;
        end
        rst = 0;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
